hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Decides each cycle whether PC and IF_ID hold
//  (stall) and whether IF_ID / ID_EX are cleared (flush/bubble).

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: FSM encodings,
// the hardwired-zero register index and a small compile-time helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HC_RUN      = 2'd0,
    HC_LD_STALL = 2'd1,
    HC_BR_FLUSH = 2'd2
  } hc_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic int hc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: one-cycle update on i_inc, synchronous clear, sticks at all-ones.
// Never backpressures; increments requested while saturated are dropped.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall on load-use, flush on taken branch, perf counters.
// Decisions are combinational in the same cycle as the inputs; FSM state shapes later cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_MemRead,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_taken,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int CW = $clog2(hc_max(LOAD_LAT, FLUSH_CYCLES) + 1);

  hc_state_e     r_state;
  logic [CW-1:0] r_cnt;

  logic w_hit;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_hit = i_ex_MemRead && (i_ex_rd != REG_X0) &&
                 ((i_ex_rd == i_id_rs1) || (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));

  always_comb begin
    o_pc_write    = 1'b1;
    o_if_id_write = 1'b1;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    if (i_reset) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_flush_if_id = 1'b1;
      o_flush_id_ex = 1'b1;
    end else if (i_ex_branch_taken) begin
      // An older branch redirect wins in every state, including mid-stall.
      o_flush_if_id = 1'b1;
      o_flush_id_ex = 1'b1;
      w_flush_inc   = 1'b1;
    end else begin
      case (r_state)
        HC_LD_STALL: begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_flush_id_ex = 1'b1;
          w_stall_inc   = 1'b1;
        end
        HC_BR_FLUSH: begin
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
        end
        default: begin
          if (w_hit) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_flush_id_ex = 1'b1;
            w_stall_inc   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= HC_RUN;
      r_cnt   <= '0;
    end else if (i_ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        r_state <= HC_BR_FLUSH;
        r_cnt   <= CW'(FLUSH_CYCLES - 1);
      end else begin
        r_state <= HC_RUN;
        r_cnt   <= '0;
      end
    end else begin
      case (r_state)
        HC_LD_STALL, HC_BR_FLUSH: begin
          if (r_cnt == CW'(1)) begin
            r_state <= HC_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= HC_RUN;
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= HC_LD_STALL;
            r_cnt   <= CW'(LOAD_LAT - 1);
          end
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_reset),
    .i_inc   (w_stall_inc),
    .o_count (o_stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_reset),
    .i_inc   (w_flush_inc),
    .o_count (o_flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: instance A uses default latencies, instance B uses LOAD_LAT=3,
// FLUSH_CYCLES=2 and narrow counters so saturation is reachable.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, ex_br;

  logic        a_pc_write, a_if_id_write, a_flush_if_id, a_flush_id_ex;
  logic [31:0] a_stall_count, a_flush_count;
  logic        b_pc_write, b_if_id_write, b_flush_if_id, b_flush_id_ex;
  logic [3:0]  b_stall_count, b_flush_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(32)) u_a (
    .i_clk(clk), .i_reset(reset), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs2(id_uses_rs2), .i_ex_MemRead(ex_memread), .i_ex_rd(ex_rd),
    .i_ex_branch_taken(ex_br), .o_pc_write(a_pc_write), .o_if_id_write(a_if_id_write),
    .o_flush_if_id(a_flush_if_id), .o_flush_id_ex(a_flush_id_ex),
    .o_stall_count(a_stall_count), .o_flush_count(a_flush_count)
  );

  hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
    .i_clk(clk), .i_reset(reset), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs2(id_uses_rs2), .i_ex_MemRead(ex_memread), .i_ex_rd(ex_rd),
    .i_ex_branch_taken(ex_br), .o_pc_write(b_pc_write), .o_if_id_write(b_if_id_write),
    .o_flush_if_id(b_flush_if_id), .o_flush_id_ex(b_flush_id_ex),
    .o_stall_count(b_stall_count), .o_flush_count(b_flush_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs2 = 1'b0; ex_memread = 1'b0; ex_br = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (a_pc_write !== 1'b0 || a_if_id_write !== 1'b0) begin errors++; $display("FAIL reset_hold: pc_write=%0b if_id_write=%0b want 0 0", a_pc_write, a_if_id_write); end
    tick(); tick();
    reset = 1'b0;
    // drive B into LD_STALL then reset it mid-stall for two cycles
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    tick();
    idle();
    reset = 1'b1;
    #1;
    checks++; if ({b_flush_if_id, b_flush_id_ex, b_pc_write, b_if_id_write} !== 4'b1100) begin errors++; $display("FAIL reset_mid_stall: fif,fex,pc,ifid=%b want 1100", {b_flush_if_id, b_flush_id_ex, b_pc_write, b_if_id_write}); end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if ({b_pc_write, b_if_id_write, b_flush_if_id, b_flush_id_ex} !== 4'b1100) begin errors++; $display("FAIL reset_release_run: pc,ifid,fif,fex=%b want 1100", {b_pc_write, b_if_id_write, b_flush_if_id, b_flush_id_ex}); end
    checks++; if (b_stall_count !== 4'd0 || b_flush_count !== 4'd0 || a_stall_count !== 32'd0) begin errors++; $display("FAIL reset_counters: b_stall=%0d b_flush=%0d a_stall=%0d want 0", b_stall_count, b_flush_count, a_stall_count); end
  endtask

  task automatic test_single_bubble();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    checks++; if ({a_pc_write, a_if_id_write, a_flush_id_ex, a_flush_if_id} !== 4'b0010) begin errors++; $display("FAIL bubble_decision: pc,ifid,fex,fif=%b want 0010", {a_pc_write, a_if_id_write, a_flush_id_ex, a_flush_if_id}); end
    tick();
    ex_memread = 1'b0;
    #1;
    checks++; if (a_stall_count !== 32'd1) begin errors++; $display("FAIL bubble_count: got %0d want 1", a_stall_count); end
    checks++; if (a_pc_write !== 1'b1 || a_flush_id_ex !== 1'b0) begin errors++; $display("FAIL bubble_resume: pc=%0b fex=%0b want 1 0", a_pc_write, a_flush_id_ex); end
  endtask

  task automatic test_rs2_stall();
    do_reset();
    id_rs1 = 5'd1; id_rs2 = 5'd7; ex_rd = 5'd7; id_uses_rs2 = 1'b1; ex_memread = 1'b1;
    #1;
    checks++; if (b_pc_write !== 1'b0) begin errors++; $display("FAIL rs2_stall_c1: pc_write=%0b want 0", b_pc_write); end
    tick();
    ex_memread = 1'b0;
    #1;
    checks++; if (b_pc_write !== 1'b0 || b_flush_id_ex !== 1'b1) begin errors++; $display("FAIL rs2_stall_c2: pc=%0b fex=%0b want 0 1", b_pc_write, b_flush_id_ex); end
    tick();
    checks++; if (b_pc_write !== 1'b0 || b_if_id_write !== 1'b0) begin errors++; $display("FAIL rs2_stall_c3: pc=%0b ifid=%0b want 0 0", b_pc_write, b_if_id_write); end
    tick();
    checks++; if (b_pc_write !== 1'b1 || b_stall_count !== 4'd3) begin errors++; $display("FAIL rs2_stall_end: pc=%0b stall_count=%0d want 1 3", b_pc_write, b_stall_count); end
    do_reset();
    id_rs1 = 5'd1; id_rs2 = 5'd7; ex_rd = 5'd7; id_uses_rs2 = 1'b0; ex_memread = 1'b1;
    #1;
    checks++; if (b_pc_write !== 1'b1 || b_flush_id_ex !== 1'b0) begin errors++; $display("FAIL rs2_unused_nostall: pc=%0b fex=%0b want 1 0", b_pc_write, b_flush_id_ex); end
    tick();
    checks++; if (b_stall_count !== 4'd0 || a_stall_count !== 32'd0) begin errors++; $display("FAIL rs2_unused_count: b=%0d a=%0d want 0 0", b_stall_count, a_stall_count); end
  endtask

  task automatic test_x0();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++; if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1) begin errors++; $display("FAIL x0_nostall: a_pc=%0b b_pc=%0b want 1 1", a_pc_write, b_pc_write); end
    tick();
    checks++; if (a_stall_count !== 32'd0 || b_stall_count !== 4'd0) begin errors++; $display("FAIL x0_count: a=%0d b=%0d want 0 0", a_stall_count, b_stall_count); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_br = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    #1;
    checks++; if ({b_flush_if_id, b_flush_id_ex, b_pc_write} !== 3'b111) begin errors++; $display("FAIL br_prio_c1: fif,fex,pc=%b want 111", {b_flush_if_id, b_flush_id_ex, b_pc_write}); end
    tick();
    ex_br = 1'b0;
    #1;
    checks++; if ({b_flush_if_id, b_flush_id_ex, b_pc_write, b_if_id_write} !== 4'b1111) begin errors++; $display("FAIL br_prio_c2: fif,fex,pc,ifid=%b want 1111", {b_flush_if_id, b_flush_id_ex, b_pc_write, b_if_id_write}); end
    checks++; if (a_flush_if_id !== 1'b0 || a_flush_count !== 32'd1) begin errors++; $display("FAIL br_single_window: a_fif=%0b a_flush_count=%0d want 0 1", a_flush_if_id, a_flush_count); end
    tick();
    ex_memread = 1'b0;
    #1;
    checks++; if (b_flush_if_id !== 1'b0 || b_flush_id_ex !== 1'b0) begin errors++; $display("FAIL br_prio_end: fif=%0b fex=%0b want 0 0", b_flush_if_id, b_flush_id_ex); end
    checks++; if (b_flush_count !== 4'd1 || b_stall_count !== 4'd0) begin errors++; $display("FAIL br_prio_counts: flush=%0d stall=%0d want 1 0", b_flush_count, b_stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_br = 1'b1;
    tick();
    #1;
    checks++; if (b_flush_if_id !== 1'b1) begin errors++; $display("FAIL b2b_second: fif=%0b want 1", b_flush_if_id); end
    tick();
    ex_br = 1'b0;
    #1;
    checks++; if (b_flush_if_id !== 1'b1 || b_pc_write !== 1'b1) begin errors++; $display("FAIL b2b_extended: fif=%0b pc=%0b want 1 1", b_flush_if_id, b_pc_write); end
    tick();
    checks++; if (b_flush_if_id !== 1'b0 || b_flush_count !== 4'd2) begin errors++; $display("FAIL b2b_end: fif=%0b flush_count=%0d want 0 2", b_flush_if_id, b_flush_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (b_stall_count !== 4'd14) begin errors++; $display("FAIL sat_pre: stall_count=%0d want 14", b_stall_count); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (b_stall_count !== 4'hF) begin errors++; $display("FAIL sat_hold: stall_count=%0d want 15", b_stall_count); end
    checks++; if (a_stall_count !== 32'd20) begin errors++; $display("FAIL sat_wide: a_stall_count=%0d want 20", a_stall_count); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_single_bubble();
    test_rs2_stall();
    test_x0();
    test_branch_priority();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
